reg_write_arb: RTL
==================

REG_WRITE_ARB -- requirements
Module: reg_write_arb

Interface
REQ-001 Parameters SHALL be: WIDTH, 16, data width; DEPTH, 8, register count; NREQ, 4, requester count; MAX_BURST, 4, longest locked grant run; AW, $clog2(DEPTH), derived address width.
REQ-002 clk  input  1  single clock; active edge SHALL be the codebase-wide clk_trigger_edge definition.
REQ-003 rst  input  1  reset; SHALL be asynchronous and active-high.
REQ-004 req_valid  input  NREQ  per-requester write request.
REQ-005 req_lock  input  NREQ  requester asks to keep ownership after the current write.
REQ-006 req_addr  input  NREQ*AW  packed target register index, requester i at [i*AW +: AW].
REQ-007 req_data  input  NREQ*WIDTH  packed write data.
REQ-008 req_ready  output  NREQ  one-hot grant, combinational from state and req_valid.
REQ-009 rf_we  output  1  registered write enable to the register file.
REQ-010 rf_write_reg  output  AW  registered write index.
REQ-011 rf_write_data  output  WIDTH  registered write data.
REQ-012 owner  output  $clog2(NREQ)  index of the last granted requester.
REQ-013 locked  output  1  high while in the LOCKED state.

Function
REQ-014 A write SHALL transfer on a cycle when req_valid[i] and req_ready[i] are both high; at most one req_ready bit SHALL be high per cycle.
REQ-015 The FSM states SHALL be IDLE, ARB and LOCKED.
REQ-016 IDLE SHALL go to ARB on any req_valid; otherwise it SHALL hold.
REQ-017 In IDLE and ARB, the grant SHALL be round-robin: the first valid requester strictly after the rr pointer, wrapping from NREQ-1 to 0.
REQ-018 The rr pointer SHALL update to the granted index on each transfer.
REQ-019 ARB SHALL go to IDLE when no req_valid is high.
REQ-020 A transfer with req_lock[i] high SHALL go to LOCKED, set owner to i and load the burst counter with 1.
REQ-021 In LOCKED, only owner SHALL be granted; other requesters SHALL see req_ready low even if valid.
REQ-022 Each owner transfer in LOCKED SHALL increment the burst counter.
REQ-023 LOCKED SHALL exit to ARB when the owner drops req_lock, drops req_valid, or completes the MAX_BURST-th write, whichever comes first; the rr pointer SHALL then equal owner, so the owner has lowest priority.
REQ-024 rf_we/rf_write_reg/rf_write_data SHALL present a transfer exactly one cycle after the handshake; rf_we SHALL be low on cycles following no transfer.
REQ-025 Back-to-back transfers SHALL sustain one write per cycle with no bubble.
REQ-026 A requester with valid high SHALL be granted within (NREQ-1)*MAX_BURST+1 cycles (starvation bound).
REQ-027 If several requesters target the same index in consecutive cycles, the writes SHALL be issued in grant order; there is no merging.

Reset
REQ-028 While rst is high: state=IDLE, rr pointer=NREQ-1 (requester 0 wins first), burst counter=0, owner=0, locked=0, rf_we=0, rf_write_reg=0, rf_write_data=0, req_ready=0.
REQ-029 Reset asserted mid-LOCKED SHALL abort the burst; a registered write not yet issued SHALL be discarded (rf_we=0).

Configuration
REQ-030 With REG_WRITE_ARB_BYPASS_EN defined, the block SHALL add inputs rd_addr1/rd_addr2 (AW) and rf_rd1/rf_rd2 (WIDTH), plus outputs fwd_rd1/fwd_rd2 (WIDTH); fwd_rdN SHALL equal rf_write_data when rf_we is high and rd_addrN==rf_write_reg, and SHALL equal rf_rdN otherwise (combinational).
REQ-031 Without REG_WRITE_ARB_BYPASS_EN, these ports and the logic SHALL be absent.

Structure
REQ-032 FSM state encodings and the clk_trigger_edge definition SHALL live in the shared define file.
REQ-033 The round-robin selection SHALL be a combinational sub-module rr_pick (NREQ-bit request, pointer in; one-hot grant, index out).

Verification
REQ-034 Reset: rst=1 with all req_valid high -> req_ready=0000, rf_we=0; release rst -> requester 0 granted first.
REQ-035 Round-robin: req_valid=1111 for 4 cycles, addr=i, data=0x10+i -> grants 0,1,2,3; rf_write_data 0x10..0x13 one cycle later each.
REQ-036 Lock: req_lock[2]=1 and req_valid=0110 held -> requester 2 gets exactly 4 grants (MAX_BURST), then 1 is granted.
REQ-037 Lock drop: owner 1 clears req_lock after 2 writes -> next cycle ARB, requester 2 granted, locked=0.
REQ-038 Async reset mid-burst: rst pulses between clock edges during LOCKED -> locked=0 and rf_we=0 immediately, state IDLE.
REQ-039 BYPASS_EN: write 0xBEEF to index 5 while rd_addr1=5 and rf_rd1=0x0000 -> fwd_rd1=0xBEEF on the rf_we cycle, then 0x0000 once rf_rd1 still reads stale data and rf_we is low.

Source files
------------

// File: rtl/reg_write_arb_pkg.sv
// Shared definitions for the register-write arbiter: active clock edge and FSM encoding.
// Optional write-to-read bypass ports are enabled by defining REG_WRITE_ARB_BYPASS_EN.
`ifndef CLK_TRIGGER_EDGE
`define CLK_TRIGGER_EDGE posedge
`endif

package reg_write_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARB    = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/reg_write_arb_rr_pick.sv
// Combinational round-robin selector: first set request strictly after ptr, wrapping.
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);

  always_comb begin : p_pick
    int j;
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant = '0;
    idx   = '0;
    j     = 0;
    // Scan from farthest to nearest so the nearest request after ptr overwrites the rest.
    for (int k = NREQ; k >= 1; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/reg_write_arb.sv
// Round-robin register-file write arbiter with locked bursts and a registered write port.
// Define REG_WRITE_ARB_BYPASS_EN to add the write-to-read forwarding ports.
module reg_write_arb #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0]           req_lock,
  input  logic [NREQ*AW-1:0]        req_addr,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      rf_we,
  output logic [AW-1:0]             rf_write_reg,
  output logic [WIDTH-1:0]          rf_write_data,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      locked
`ifdef REG_WRITE_ARB_BYPASS_EN
  ,
  input  logic [AW-1:0]             rd_addr1,
  input  logic [AW-1:0]             rd_addr2,
  input  logic [WIDTH-1:0]          rf_rd1,
  input  logic [WIDTH-1:0]          rf_rd2,
  output logic [WIDTH-1:0]          fwd_rd1,
  output logic [WIDTH-1:0]          fwd_rd2
`endif
);

  import reg_write_arb_pkg::*;

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [CW-1:0]   burst_cnt;
  logic [NREQ-1:0] pick_grant;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   gnt_idx;
  logic            xfer;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // Grants are suppressed while reset is held, even though state already reads IDLE.
  always_comb begin
    req_ready = '0;
    gnt_idx   = pick_idx;
    if (!rst) begin
      if (state == ST_LOCKED) begin
        gnt_idx          = owner;
        req_ready[owner] = req_valid[owner];
      end else begin
        req_ready = pick_grant;
      end
    end
  end

  assign xfer = |req_ready;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(`CLK_TRIGGER_EDGE clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      rr_ptr        <= IW'(NREQ - 1);
      burst_cnt     <= '0;
      owner         <= '0;
      locked        <= 1'b0;
      rf_we         <= 1'b0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
    end else begin
      rf_we <= xfer;
      if (xfer) begin
        rf_write_reg  <= req_addr[gnt_idx*AW +: AW];
        rf_write_data <= req_data[gnt_idx*WIDTH +: WIDTH];
        rr_ptr        <= gnt_idx;
        owner         <= gnt_idx;
      end
      case (state)
        ST_IDLE, ST_ARB: begin
          if (xfer && req_lock[gnt_idx]) begin
            state     <= ST_LOCKED;
            locked    <= 1'b1;
            burst_cnt <= CW'(1);
          end else if (|req_valid) begin
            state <= ST_ARB;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_LOCKED: begin
          if (xfer) burst_cnt <= burst_cnt + CW'(1);
          // Leaving LOCKED keeps rr_ptr at owner, giving it lowest priority next.
          if (!xfer || !req_lock[owner] || burst_cnt == CW'(MAX_BURST - 1)) begin
            state  <= ST_ARB;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          locked <= 1'b0;
        end
      endcase
    end
  end

`ifdef REG_WRITE_ARB_BYPASS_EN
  assign fwd_rd1 = (rf_we && rd_addr1 == rf_write_reg) ? rf_write_data : rf_rd1;
  assign fwd_rd2 = (rf_we && rd_addr2 == rf_write_reg) ? rf_write_data : rf_rd2;
`endif

endmodule
